// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling 8N1 UART receiver front end.
// Synchronizes the serial line, frames characters on mid-bit samples and
// emits a one-cycle FIFO write strobe; flags framing and overrun errors.
module uart_rx_sampler #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic                 i_rx,
    input  logic                 i_full,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n, ovr_n;

    // Register stage: line synchronizer, FSM state, counters and outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            rx_m        <= i_rx;
            rx_s        <= rx_m;
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
            o_frame_err <= ferr_n;
            o_overrun   <= ovr_n;
        end
    end

    // Next-state logic: counters only move on baud ticks; decisions are
    // taken at mid-bit (start) or one full bit period later (data, stop).
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = o_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        ovr_n   = o_overrun;

        case (state)
            S_IDLE: begin
                tick_n = '0;
                bit_n  = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_n   = '0;
                            state_n = S_STOP;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        if (rx_s) begin
                            if (!i_full) begin
                                data_n  = shift;
                                valid_n = 1'b1;
                            end else begin
                                ovr_n = 1'b1;
                            end
                            state_n = S_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = S_BREAK;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                tick_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receive front end that turns the asynchronous serial line into 8-bit words and pushes them into the receive FIFO. It oversamples the line using an external baud-tick strobe, frames 8N1 characters, and issues a one-cycle write strobe that connects directly to the FIFO write input. It honours the FIFO full flag and reports framing and overrun errors.

## Interface

Parameters:
- DATA_BITS, 8, payload bits per character, sent LSB first.
- OVERSAMPLE, 16, baud ticks per bit period; must be even and ≥ 4.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst  in  1  reset: one clock, synchronous, active-low.
- i_tick  in  1  baud×OVERSAMPLE strobe, one i_clk cycle wide.
- i_rx  in  1  serial line, asynchronous, idle high.
- i_full  in  1  FIFO full flag.
- o_data  out  DATA_BITS  last accepted character; feeds FIFO i_data.
- o_valid  out  1  one-cycle write strobe; feeds FIFO i_write.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  sticky: a good character was dropped because i_full was high.

## Operation

- i_rx passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
- A tick counter (width $clog2(OVERSAMPLE)) and a bit counter (width $clog2(DATA_BITS)) advance only on cycles with i_tick=1.
- FSM states:
  - IDLE: tick count held at 0. When rx_s=0, go to START.
  - START: on the tick where count = OVERSAMPLE/2−1 (mid-bit), if rx_s=0, clear counts and go to DATA. If rx_s=1, treat it as a glitch and return to IDLE.
  - DATA: on the tick where count = OVERSAMPLE−1, shift rx_s into the MSB of the shift register (so the result is LSB-first), clear the count, and increment the bit counter. After bit DATA_BITS−1, go to STOP.
  - STOP: on the tick where count = OVERSAMPLE−1, sample rx_s:
    - rx_s=1 and i_full=0: load o_data from the shift register, pulse o_valid, go to IDLE.
    - rx_s=1 and i_full=1: drop the character, set o_overrun, leave o_data unchanged, go to IDLE.
    - rx_s=0: pulse o_frame_err, drop the character, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a line held low from retriggering reception.
- o_overrun clears only on reset.
- o_data holds its value between accepted characters.

## Timing

- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, state=IDLE, counters=0, synchronizer=1.
- Reset asserted mid-frame aborts the character on the next posedge. No o_valid is issued for it.
- o_valid and o_frame_err are registered, exactly one i_clk wide, and never high in the same cycle.
- o_data is valid in the same cycle as o_valid and stays stable afterwards. The FIFO captures it on the following negedge.
- i_full is sampled only on the stop-bit decision cycle.
- Latency: o_valid rises one i_clk after the stop-bit mid-sample tick. Counted from the line falling edge this is about (DATA_BITS+1)·OVERSAMPLE + OVERSAMPLE/2 ticks, plus 2–3 clocks for the synchronizer.
- Consecutive characters need no gap. The next start edge is detected in IDLE on the cycle after the STOP decision.
- Ticks do not advance the FSM while in IDLE or BREAK.
- No behaviour depends on i_tick arriving on consecutive clocks. The bench may space ticks at any interval ≥ 1 clock.

## Test plan

- Basic receive: ticks every 4 clocks; send 8N1 0xA5 with i_full=0. Required: o_data=0xA5 with a single o_valid pulse; o_frame_err=0; o_overrun=0.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap. Required: three o_valid pulses carrying 0x00, 0xFF, 0x3C in order.
- Glitch rejection: drive i_rx low for 3 ticks, then high. Required: FSM returns to IDLE; no o_valid; no o_frame_err. A following 0x5A is received correctly.
- Framing error: send 0x81 with the stop bit low, then hold the line low for 40 ticks, then release. Required: one o_frame_err pulse; no o_valid; no further activity until the line goes high. A subsequent 0x42 is received correctly.
- Overrun: hold i_full=1 and send 0x77. Required: no o_valid, o_overrun=1, and o_data keeps its prior value. Drop i_full and send 0x11. Required: o_valid with 0x11, and o_overrun still 1.
- Reset mid-frame: assert i_rst=0 for one clock during data bit 4. Required: all outputs 0 on the next cycle, no o_valid for the aborted character, and the next full frame 0xC3 is received correctly.
